// File: rtl/irq_ctrl.sv
// irq_ctrl: N_SRC-source edge-triggered interrupt controller for the jacaranda-8 data-memory port.
// Optional macro IRQ_CTRL_SYNC_EN inserts a two-flop synchroniser on every src bit before edge detection.
module irq_ctrl #(
  parameter int         N_SRC     = 4,
  parameter logic [7:0] BASE_ADDR = 8'd232
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_n,
  input  logic [N_SRC-1:0] src,
  input  logic [7:0]       addr,
  input  logic [7:0]       w_data,
  input  logic             w_en,
  output logic [7:0]       r_data,
  output logic             r_hit,
  output logic             int_req,
  output logic [7:0]       int_vec,
  output logic [7:0]       int_en
);
  typedef enum logic [1:0] {IDLE, DISPATCH, SERVICE} state_t;
  state_t           r_state;
  logic [N_SRC-1:0] r_prev, r_pending, r_mask;
  logic [7:0]       r_vec [N_SRC];
  logic [2:0]       r_active;
  logic [N_SRC-1:0] w_src, w_edge, w_req, w_w1c, w_clr;
  logic [7:0]       w_off, w_sel_vec;
  logic [2:0]       w_sel;
  logic             w_wr, w_go, w_eoi;
`ifdef IRQ_CTRL_SYNC_EN
  logic [N_SRC-1:0] r_sync1, r_sync2;
  // two-flop synchroniser for asynchronous pad-driven sources
  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= src;
      r_sync2 <= r_sync1;
    end
  end
  assign w_src = r_sync2;
`else
  assign w_src = src;
`endif
  // window offset wraps below BASE_ADDR, so a single compare covers both ends
  assign w_off  = addr - BASE_ADDR;
  assign r_hit  = w_off < 8'(4 + N_SRC);
  assign w_wr   = w_en & r_hit;
  assign w_edge = w_src & ~r_prev;
  assign w_req  = r_pending & r_mask;
  assign w_go   = (r_state == IDLE) && (|w_req);
  assign w_eoi  = w_wr && (w_off == 8'd3) && (r_state == SERVICE);
  assign w_w1c  = (w_wr && w_off == 8'd0) ? w_data[N_SRC-1:0] : '0;
  // lowest enabled pending index wins; its vector and pending-clear follow
  always_comb begin
    w_sel     = '0;
    w_sel_vec = 8'h00;
    w_clr     = '0;
    for (int i = N_SRC - 1; i >= 0; i--) if (w_req[i]) w_sel = 3'(i);
    for (int i = 0; i < N_SRC; i++) begin
      if (w_sel == 3'(i)) w_sel_vec = r_vec[i];
      w_clr[i] = w_go && (w_sel == 3'(i));
    end
  end
  // zero-latency register read mux for the parent data-memory select
  always_comb begin
    r_data = 8'h00;
    if (r_hit) begin
      r_data = (w_off == 8'd0) ? 8'(r_pending) :
               (w_off == 8'd1) ? 8'(r_mask) :
               (w_off == 8'd2) ? {r_state != IDLE, 4'b0000, r_active} : 8'h00;
      for (int i = 0; i < N_SRC; i++) if (w_off == 8'(4 + i)) r_data = r_vec[i];
    end
  end
  // vector table writes
  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      for (int i = 0; i < N_SRC; i++) r_vec[i] <= 8'h00;
    end else begin
      for (int i = 0; i < N_SRC; i++) if (w_wr && w_off == 8'(4 + i)) r_vec[i] <= w_data;
    end
  end
  // edge capture, mask, dispatch FSM and registered CPU-facing outputs
  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      r_prev    <= '0;
      r_pending <= '0;
      r_mask    <= '0;
      r_active  <= '0;
      r_state   <= IDLE;
      int_req   <= 1'b0;
      int_vec   <= 8'h00;
      int_en    <= 8'h01;
    end else begin
      r_prev    <= w_src;
      r_pending <= (r_pending & ~w_w1c & ~w_clr) | w_edge;
      if (w_wr && w_off == 8'd1) r_mask <= w_data[N_SRC-1:0];
      if (w_go) begin
        r_active <= w_sel;
        int_vec  <= w_sel_vec;
      end
      int_req <= w_go;
      r_state <= w_go ? DISPATCH : (r_state == DISPATCH) ? SERVICE : w_eoi ? IDLE : r_state;
      int_en  <= (w_go || r_state == DISPATCH || (r_state == SERVICE && !w_eoi)) ? 8'h00 : 8'h01;
    end
  end
endmodule

// File: tb/tb_irq_ctrl.sv
// tb_irq_ctrl: directed literal checks plus randomized traffic against a behavioural model of irq_ctrl.
`timescale 1ns/1ps
module tb_irq_ctrl;
  localparam int         N    = 4;
  localparam logic [7:0] BASE = 8'd232;
  localparam bit   [7:0] NM   = 8'((1 << N) - 1);
`ifdef IRQ_CTRL_SYNC_EN
  localparam int SL = 2;
`else
  localparam int SL = 0;
`endif
  logic         clk = 1'b0, rst_n = 1'b0, w_en = 1'b0;
  logic [N-1:0] src = '0;
  logic [7:0]   addr = 8'h00, w_data = 8'h00;
  logic [7:0]   r_data, int_vec, int_en;
  logic         r_hit, int_req;
  int           vectors = 0, errors = 0;

  irq_ctrl #(.N_SRC(N), .BASE_ADDR(BASE)) dut (
    .wb_clk_i(clk), .wb_rst_n(rst_n), .src(src), .addr(addr), .w_data(w_data), .w_en(w_en),
    .r_data(r_data), .r_hit(r_hit), .int_req(int_req), .int_vec(int_vec), .int_en(int_en)
  );

  always #5 clk = ~clk;

  // model: pending/mask/vector tables plus "busy" (an interrupt is owned) and "req" (first owned cycle)
  bit [7:0] m_pend, m_mask, m_prev, m_vout, m_s1, m_s2;
  bit [7:0] m_vec [N];
  bit [2:0] m_act;
  bit       m_busy, m_req;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pend = 0; m_mask = 0; m_prev = 0; m_vout = 0; m_s1 = 0; m_s2 = 0;
      m_act = 0; m_busy = 0; m_req = 0;
      for (int i = 0; i < N; i++) m_vec[i] = 0;
    end else begin : upd
      bit [7:0] s, req, np;
      int       idx, off;
      bit       take, eoi;
      s    = (SL != 0) ? m_s2 : 8'(src);
      m_s2 = m_s1;
      m_s1 = 8'(src);
      off  = int'(addr) - int'(BASE);
      req  = m_pend & m_mask;
      take = !m_busy && (req != 0);
      idx  = 0;
      for (int i = N - 1; i >= 0; i--) if (req[i]) idx = i;
      eoi  = w_en && off == 3 && m_busy && !m_req;
      np   = m_pend & ~((w_en && off == 0) ? w_data : 8'h00);
      if (take) np[idx] = 1'b0;
      np   = (np | (s & ~m_prev)) & NM;
      if (take) begin
        m_act  = 3'(idx);
        m_vout = m_vec[idx];
      end
      if (w_en && off == 1) m_mask = w_data & NM;
      for (int i = 0; i < N; i++) if (w_en && off == 4 + i) m_vec[i] = w_data;
      if (take) m_busy = 1'b1;
      else if (eoi) m_busy = 1'b0;
      m_req  = take;
      m_prev = s;
      m_pend = np;
    end
  end

  function automatic bit exp_hit(input logic [7:0] a);
    int off = int'(a) - int'(BASE);
    return off >= 0 && off <= 3 + N;
  endfunction

  function automatic logic [7:0] exp_rd(input logic [7:0] a);
    int off = int'(a) - int'(BASE);
    if (off == 0) return m_pend;
    if (off == 1) return m_mask;
    if (off == 2) return {m_busy, 4'b0000, m_act};
    if (off >= 4 && off < 4 + N) return m_vec[off - 4];
    return 8'h00;
  endfunction

  // every-cycle comparison of all outputs against the model
  always @(negedge clk) begin
    vectors++;
    if (int_req !== m_req) begin errors++; $display("FAIL int_req t=%0t got %b want %b", $time, int_req, m_req); end
    if (int_en !== (m_busy ? 8'h00 : 8'h01)) begin errors++; $display("FAIL int_en t=%0t got %02h want %02h", $time, int_en, m_busy ? 8'h00 : 8'h01); end
    if (int_vec !== m_vout) begin errors++; $display("FAIL int_vec t=%0t got %02h want %02h", $time, int_vec, m_vout); end
    if (r_hit !== exp_hit(addr)) begin errors++; $display("FAIL r_hit t=%0t addr=%0d got %b want %b", $time, addr, r_hit, exp_hit(addr)); end
    if (r_data !== exp_rd(addr)) begin errors++; $display("FAIL r_data t=%0t addr=%0d got %02h want %02h", $time, addr, r_data, exp_rd(addr)); end
  end

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    vectors++;
    if (act !== exp) begin errors++; $display("FAIL %s got %02h want %02h", nm, act, exp); end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    addr = a; w_data = d; w_en = 1'b1;
    step();
    w_en = 1'b0;
  endtask

  task automatic rd(input string nm, input logic [7:0] a, input logic [7:0] exp);
    addr = a;
    #1;
    chk(nm, r_data, exp);
  endtask

  initial begin
    repeat (2) step();
    rst_n = 1'b1;
    step();
    chk("rst_int_en", int_en, 8'h01);
    chk("rst_int_req", 8'(int_req), 8'h00);
    for (int i = 0; i < 7; i++) begin
      rd($sformatf("rst_reg%0d", i), BASE + 8'(i), 8'h00);
      chk("rst_hit", 8'(r_hit), 8'h01);
    end
    addr = 8'd231;
    #1;
    chk("below_hit", 8'(r_hit), 8'h00);
    chk("below_data", r_data, 8'h00);
    // single source dispatch and EOI
    wr(BASE + 8'd1, 8'h0F);
    wr(BASE + 8'd6, 8'h40);
    src = 4'b0100; step(); src = '0;
    repeat (SL) step();
    chk("one_pre_req", 8'(int_req), 8'h00);
    step();
    chk("one_req", 8'(int_req), 8'h01);
    chk("one_vec", int_vec, 8'h40);
    chk("one_en_disp", int_en, 8'h00);
    rd("one_active", BASE + 8'd2, 8'h82);
    step();
    chk("one_req_off", 8'(int_req), 8'h00);
    chk("one_en_svc", int_en, 8'h00);
    step();
    chk("one_en_svc2", int_en, 8'h00);
    wr(BASE + 8'd3, 8'h00);
    chk("one_en_eoi", int_en, 8'h01);
    chk("one_vec_hold", int_vec, 8'h40);
    // two sources on one edge: priority and the mandatory IDLE cycle
    src = 4'b1010; step(); src = '0;
    repeat (SL) step();
    step();
    chk("pri_req1", 8'(int_req), 8'h01);
    rd("pri_act1", BASE + 8'd2, 8'h81);
    step();
    wr(BASE + 8'd3, 8'h00);
    chk("pri_idle_en", int_en, 8'h01);
    chk("pri_idle_req", 8'(int_req), 8'h00);
    step();
    chk("pri_req2", 8'(int_req), 8'h01);
    rd("pri_act2", BASE + 8'd2, 8'h83);
    step();
    wr(BASE + 8'd3, 8'h00);
    // masked source latches, dispatches one cycle after unmasking
    wr(BASE + 8'd1, 8'h00);
    src = 4'b0001; step(); src = '0;
    repeat (SL) step();
    rd("msk_pend", BASE, 8'h01);
    step();
    chk("msk_noreq", 8'(int_req), 8'h00);
    wr(BASE + 8'd1, 8'h01);
    chk("msk_old_mask", 8'(int_req), 8'h00);
    step();
    chk("msk_req", 8'(int_req), 8'h01);
    step();
    wr(BASE + 8'd3, 8'h00);
    // edge set beats a same-edge W1C
    wr(BASE + 8'd1, 8'h00);
    src = 4'b0010;
    repeat (SL) begin step(); src = '0; end
    addr = BASE; w_data = 8'h02; w_en = 1'b1;
    step();
    w_en = 1'b0; src = '0;
    rd("w1c_set_wins", BASE, 8'h02);
    wr(BASE, 8'h02);
    rd("w1c_clear", BASE, 8'h00);
    // asynchronous reset in the middle of service
    wr(BASE + 8'd1, 8'h0F);
    src = 4'b0001; step(); src = '0;
    repeat (SL) step();
    step(); step();
    chk("rs_svc_en", int_en, 8'h00);
    rst_n = 1'b0;
    #1;
    chk("rs_en", int_en, 8'h01);
    chk("rs_req", 8'(int_req), 8'h00);
    chk("rs_vec", int_vec, 8'h00);
    rd("rs_active", BASE + 8'd2, 8'h00);
    rd("rs_mask", BASE + 8'd1, 8'h00);
    step();
    rst_n = 1'b1;
    // randomized traffic, checked every cycle against the model
    for (int c = 0; c < 3000; c++) begin
      rst_n  = ($urandom_range(0, 599) != 0);
      if ($urandom_range(0, 3) == 0) src = src ^ N'(1 << $urandom_range(0, N - 1));
      w_en   = ($urandom_range(0, 2) == 0);
      addr   = BASE - 8'd2 + 8'($urandom_range(0, N + 5));
      if ($urandom_range(0, 3) == 0) addr = BASE + 8'd3;
      w_data = 8'($urandom);
      step();
    end
    rst_n = 1'b1; w_en = 1'b0;
    repeat (3) step();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
